mem_io_responder: RTL and testbench

- Bus responder at the far end of the processor's memory interface. Samples the processor's ADDR, Dout and W each clock, decodes the address, and performs the write or returns read data on Din.
- Contains a 128-word synchronous RAM, an LED output register, a display data register, a synchronized switch input port and a prescaled 9-bit timer with a sticky wrap flag.
- Sits between the processor and board I/O in the top level.

---
 rtl/mem_io_responder.sv | 147 ++++++++++++++
 tb/tb_mem_io_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: far-end responder on the processor memory bus.
// Decodes ADDR every cycle and returns registered read data on Din with
// one cycle of latency. Write data lands in the addressed RAM word or I/O
// register on the same edge. Reads always return the value from before
// that edge.
// Also holds the LED and display registers, a synchronized switch port,
// and a prescaled 9-bit timer with a sticky wrap flag.

module mem_io_responder #(
    parameter int RAM_DEPTH   = 128,
    parameter int PRESCALE    = 50,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] ADDR,
    input  logic [8:0] Dout,
    input  logic       W,
    output logic [8:0] Din,
    input  logic [8:0] SW,
    output logic [8:0] LEDR,
    output logic [8:0] HEX_DATA,
    output logic       TMR_WRAP
);

    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [7:0]    DEPTH8 = 8'(RAM_DEPTH);
    localparam logic [PW-1:0] PTERM  = PW'(PRESCALE - 1);

    localparam logic [8:0] A_LEDR  = 9'h100;
    localparam logic [8:0] A_HEX   = 9'h101;
    localparam logic [8:0] A_SW    = 9'h110;
    localparam logic [8:0] A_TCNT  = 9'h120;
    localparam logic [8:0] A_TSTAT = 9'h121;

    logic [8:0]    ram [RAM_DEPTH];
    logic [8:0]    sw_sync [SYNC_STAGES];
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic [8:0]    ram_rd;
    logic [8:0]    rd_data;
    logic [8:0]    tmr_cnt;
    logic [PW-1:0] presc;
    logic          run_en;
    logic          wrap_flag;
    logic          tick;
    logic          wr_cnt;
    logic          wr_stat;
    logic          wrap_set;

    // RAM sits in the low quarter; an index past the RAM depth is not backed by storage.
    assign ram_hit = (ADDR[8:7] == 2'b00) && ({1'b0, ADDR[6:0]} < DEPTH8);
    assign ram_idx = ADDR[AW-1:0];
    assign ram_rd  = ram[ram_idx];

    assign wr_cnt   = W && (ADDR == A_TCNT);
    assign wr_stat  = W && (ADDR == A_TSTAT);
    assign tick     = run_en && (presc == PTERM);
    // A CPU write to the counter cancels that edge's increment, so it cannot wrap.
    assign wrap_set = tick && !wr_cnt && (tmr_cnt == 9'h1FF);

    assign TMR_WRAP = wrap_flag;

    // RAM write port; contents survive reset but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && W && ram_hit) begin
            ram[ram_idx] <= Dout;
        end
    end

    // Switch synchronizer chain; the last stage is the value software sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= '0;
            end
        end else begin
            sw_sync[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= sw_sync[i-1];
            end
        end
    end

    // Read mux; this sees pre-edge state, so Din returns the old value.
    always_comb begin
        rd_data = '0;
        if (ram_hit) begin
            rd_data = ram_rd;
        end else begin
            case (ADDR)
                A_LEDR:  rd_data = LEDR;
                A_HEX:   rd_data = HEX_DATA;
                A_SW:    rd_data = sw_sync[SYNC_STAGES-1];
                A_TCNT:  rd_data = tmr_cnt;
                A_TSTAT: rd_data = {7'b0, run_en, wrap_flag};
                default: rd_data = '0;
            endcase
        end
    end

    // Registered read data plus the two plain output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            Din      <= '0;
            LEDR     <= '0;
            HEX_DATA <= '0;
        end else begin
            Din <= rd_data;
            if (W && ADDR == A_LEDR) begin
                LEDR <= Dout;
            end
            if (W && ADDR == A_HEX) begin
                HEX_DATA <= Dout;
            end
        end
    end

    // Timer: prescaler, counter, run enable and sticky wrap flag (a set beats a clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            tmr_cnt   <= '0;
            run_en    <= 1'b1;
            wrap_flag <= 1'b0;
        end else begin
            if (run_en) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            if (wr_cnt) begin
                tmr_cnt <= Dout;
            end else if (tick) begin
                tmr_cnt <= tmr_cnt + 9'd1;
            end
            if (wrap_set) begin
                wrap_flag <= 1'b1;
            end else if (wr_stat && Dout[0]) begin
                wrap_flag <= 1'b0;
            end
            if (wr_stat) begin
                run_en <= Dout[1];
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder with PRESCALE=2. The counter
// therefore ticks on every second running edge after a reset.

module tb_mem_io_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] addr;
    logic [8:0] dout;
    logic       w;
    logic [8:0] sw;
    logic [8:0] din;
    logic [8:0] ledr;
    logic [8:0] hex_data;
    logic       tmr_wrap;

    int test_count = 0;
    int fail_count = 0;

    mem_io_responder #(
        .RAM_DEPTH(128),
        .PRESCALE(2),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ADDR(addr),
        .Dout(dout),
        .W(w),
        .Din(din),
        .SW(sw),
        .LEDR(ledr),
        .HEX_DATA(hex_data),
        .TMR_WRAP(tmr_wrap)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Drive one bus cycle, then settle just after the rising edge
    task automatic applyStimulus(input logic [8:0] a, input logic [8:0] d, input logic we);
        addr = a;
        dout = d;
        w    = we;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%03h expected 0x%03h", tag, observed, expected);
        end
    endtask

    // Directed sequence: every expected value below is worked out by hand
    initial begin
        rst  = 1'b1;
        addr = '0;
        dout = '0;
        w    = 1'b0;
        sw   = '0;
        applyStimulus(9'h000, 9'h000, 1'b0);
        applyStimulus(9'h000, 9'h000, 1'b0);
        checkOutput("reset_din", din, 9'h000);
        checkOutput("reset_ledr", ledr, 9'h000);
        checkOutput("reset_hex", hex_data, 9'h000);
        checkOutput("reset_wrap", {8'b0, tmr_wrap}, 9'h000);
        rst = 1'b0;

        applyStimulus(9'h121, 9'h000, 1'b0);
        checkOutput("reset_stat", din, 9'h002);

        // RAM write then read back, including the top index and an unmapped hole
        applyStimulus(9'h005, 9'h1A5, 1'b1);
        applyStimulus(9'h005, 9'h000, 1'b0);
        checkOutput("ram_05", din, 9'h1A5);
        applyStimulus(9'h07F, 9'h011, 1'b1);
        applyStimulus(9'h07F, 9'h000, 1'b0);
        checkOutput("ram_7f", din, 9'h011);
        applyStimulus(9'h0C0, 9'h1EE, 1'b1);
        applyStimulus(9'h0C0, 9'h000, 1'b0);
        checkOutput("unmapped_0c0", din, 9'h000);
        applyStimulus(9'h005, 9'h000, 1'b0);
        checkOutput("ram_05_kept", din, 9'h1A5);

        // Read-first collision
        applyStimulus(9'h010, 9'h003, 1'b1);
        applyStimulus(9'h010, 9'h0FF, 1'b1);
        checkOutput("collide_old", din, 9'h003);
        applyStimulus(9'h010, 9'h000, 1'b0);
        checkOutput("collide_new", din, 9'h0FF);

        // LED and display registers
        applyStimulus(9'h100, 9'h155, 1'b1);
        checkOutput("ledr_write", ledr, 9'h155);
        applyStimulus(9'h101, 9'h0C3, 1'b1);
        checkOutput("hex_write", hex_data, 9'h0C3);
        applyStimulus(9'h100, 9'h000, 1'b0);
        checkOutput("ledr_read", din, 9'h155);
        applyStimulus(9'h101, 9'h000, 1'b0);
        checkOutput("hex_read", din, 9'h0C3);

        // Switch synchronizer: two edges to reach the readable value
        sw = 9'h0F0;
        applyStimulus(9'h110, 9'h000, 1'b0);
        applyStimulus(9'h110, 9'h000, 1'b0);
        checkOutput("sw_not_yet", din, 9'h000);
        applyStimulus(9'h110, 9'h000, 1'b0);
        checkOutput("sw_synced", din, 9'h0F0);
        applyStimulus(9'h110, 9'h1FF, 1'b1);
        applyStimulus(9'h110, 9'h000, 1'b0);
        checkOutput("sw_readonly", din, 9'h0F0);

        // Timer: fresh reset so the prescaler phase is known
        rst = 1'b1;
        applyStimulus(9'h000, 9'h000, 1'b0);
        rst = 1'b0;
        applyStimulus(9'h120, 9'h1FE, 1'b1);
        applyStimulus(9'h000, 9'h000, 1'b0);
        applyStimulus(9'h000, 9'h000, 1'b0);
        applyStimulus(9'h120, 9'h000, 1'b0);
        checkOutput("tmr_before_wrap", din, 9'h1FF);
        checkOutput("tmr_wrap_set", {8'b0, tmr_wrap}, 9'h001);
        applyStimulus(9'h120, 9'h000, 1'b0);
        checkOutput("tmr_wrapped", din, 9'h000);
        applyStimulus(9'h121, 9'h000, 1'b0);
        checkOutput("tmr_stat_sticky", din, 9'h003);
        applyStimulus(9'h121, 9'h001, 1'b1);
        checkOutput("tmr_wrap_cleared", {8'b0, tmr_wrap}, 9'h000);
        applyStimulus(9'h120, 9'h000, 1'b0);
        checkOutput("tmr_stopped", din, 9'h001);
        applyStimulus(9'h121, 9'h000, 1'b0);
        checkOutput("tmr_stat_off", din, 9'h000);
        applyStimulus(9'h121, 9'h002, 1'b1);
        applyStimulus(9'h120, 9'h000, 1'b0);
        checkOutput("tmr_held", din, 9'h001);
        applyStimulus(9'h120, 9'h000, 1'b0);
        checkOutput("tmr_resumed", din, 9'h002);

        // A CPU write on a tick edge wins over the increment
        applyStimulus(9'h120, 9'h100, 1'b1);
        applyStimulus(9'h120, 9'h000, 1'b0);
        checkOutput("tmr_write_on_tick", din, 9'h100);

        // A wrap on the same edge as a flag clear leaves the flag set
        applyStimulus(9'h120, 9'h1FF, 1'b1);
        applyStimulus(9'h000, 9'h000, 1'b0);
        applyStimulus(9'h121, 9'h003, 1'b1);
        checkOutput("wrap_beats_clear", {8'b0, tmr_wrap}, 9'h001);
        applyStimulus(9'h121, 9'h003, 1'b1);
        checkOutput("stat_read_no_clear", din, 9'h003);
        checkOutput("wrap_clear_again", {8'b0, tmr_wrap}, 9'h000);

        // A write to the counter at 0x1FF on a tick edge must not set the flag
        applyStimulus(9'h120, 9'h1FF, 1'b1);
        applyStimulus(9'h000, 9'h000, 1'b0);
        applyStimulus(9'h120, 9'h050, 1'b1);
        checkOutput("write_blocks_wrap", {8'b0, tmr_wrap}, 9'h000);
        applyStimulus(9'h120, 9'h000, 1'b0);
        checkOutput("tmr_written_050", din, 9'h050);

        // Reset overrides a concurrent write
        applyStimulus(9'h100, 9'h0AA, 1'b1);
        checkOutput("ledr_before_rst", ledr, 9'h0AA);
        rst = 1'b1;
        applyStimulus(9'h100, 9'h077, 1'b1);
        rst = 1'b0;
        checkOutput("rst_ledr", ledr, 9'h000);
        checkOutput("rst_din", din, 9'h000);
        applyStimulus(9'h120, 9'h000, 1'b0);
        checkOutput("rst_tmr_cnt", din, 9'h000);
        applyStimulus(9'h100, 9'h000, 1'b0);
        checkOutput("rst_ledr_read", din, 9'h000);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
